// File: rtl/olr_lane_egress_buffer.sv
// olr_lane_egress_buffer
//
// Per-lane receive buffer that sits directly after the OLR egress stage. It
// paces the egress stage with single-cycle request pulses, captures one word
// per request into a FIFO, and drains stored words to the lane link
// transmitter over a valid/ready stream. The stream is either cut-through or
// store-and-forward, selected by STORE_FWD.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous reset, active-high
//   data_in      egress word: [34:32] flag (100 = more, 000 = last), [31:0] data; 0 = no word
//   buffer_ready registered request pulse to the egress stage
//   tx_data      payload at the FIFO head (zero when tx_valid is low)
//   tx_last      head word is the final word of a packet
//   tx_valid     tx_data/tx_last valid
//   tx_ready     transmitter accepts on tx_valid && tx_ready
//   fifo_count   number of stored words
//   pkt_count    packets fully drained since reset (wraps)
//   frame_err    sticky illegal-flag indicator
module olr_lane_egress_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter bit          STORE_FWD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [34:0]       data_in,
    output logic              buffer_ready,
    output logic [31:0]       tx_data,
    output logic              tx_last,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic [15:0]       pkt_count,
    output logic              frame_err
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StCap  = 2'd2;

    localparam logic [2:0] FlagMore = 3'b100;
    localparam logic [2:0] FlagLast = 3'b000;

    // Storage: {last, data}
    logic [32:0]       mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic              br_q, br_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   spkt_q, spkt_d;     // complete packets currently stored
    logic [15:0]       pkt_q;
    logic              ferr_q;

    logic [2:0]        flag;
    logic              push, push_last, push_bad;
    logic              pop, pop_last, valid;
    logic [32:0]       head;

    always_comb begin
        flag      = data_in[34:32];
        push      = (state_q == StCap) && (data_in != '0);
        push_last = (flag != FlagMore);
        push_bad  = (flag != FlagMore) && (flag != FlagLast);

        head      = mem[rd_ptr_q];
        valid     = (count_q != '0) && (!STORE_FWD || (spkt_q != '0));
        pop       = valid && tx_ready;
        pop_last  = head[32];

        count_d   = count_q + CntW'(push) - CntW'(pop);
        spkt_d    = spkt_q + CntW'(push && push_last) - CntW'(pop && pop_last);
    end

    // Request FSM. CAP looks at the post-edge occupancy so that a word landing
    // in the last free slot suppresses the back-to-back request.
    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle:  state_d = (count_q < DepthCnt) ? StReq : StIdle;
            StReq:   state_d = StCap;
            StCap:   state_d = (count_d < DepthCnt) ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
        br_d = (state_d == StReq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            br_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            spkt_q   <= '0;
            pkt_q    <= '0;
            ferr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            count_q <= count_d;
            spkt_q  <= spkt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            if (pop && pop_last) begin
                pkt_q <= pkt_q + 16'd1;
            end
            if (push && push_bad) begin
                ferr_q <= 1'b1;
            end
        end
    end

    // Storage array needs no reset; contents are only visible behind tx_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {push_last, data_in[31:0]};
        end
    end

    always_comb begin
        buffer_ready = br_q;
        tx_valid     = valid;
        tx_data      = valid ? head[31:0] : 32'd0;
        tx_last      = valid && head[32];
        fifo_count   = count_q;
        pkt_count    = pkt_q;
        frame_err    = ferr_q;
    end

endmodule

// File: tb/tb_olr_lane_egress_buffer.sv
module tb_olr_lane_egress_buffer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam logic [31:0] CtA    = 32'hC0DE_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic [34:0]       data_in = '0;
    logic              buffer_ready;
    logic [31:0]       tx_data;
    logic              tx_last;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [ADDR_W:0]   fifo_count;
    logic [15:0]       pkt_count;
    logic              frame_err;

    logic [34:0]       ct_data_in = '0;
    logic              ct_buffer_ready;
    logic [31:0]       ct_tx_data;
    logic              ct_tx_last;
    logic              ct_tx_valid;
    logic              ct_tx_ready = 1'b1;
    logic [ADDR_W:0]   ct_fifo_count;
    logic [15:0]       ct_pkt_count;
    logic              ct_frame_err;

    olr_lane_egress_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STORE_FWD(1'b1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .buffer_ready (buffer_ready),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_count   (fifo_count),
        .pkt_count    (pkt_count),
        .frame_err    (frame_err)
    );

    olr_lane_egress_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STORE_FWD(1'b0)) u_ct (
        .clk          (clk),
        .reset        (reset),
        .data_in      (ct_data_in),
        .buffer_ready (ct_buffer_ready),
        .tx_data      (ct_tx_data),
        .tx_last      (ct_tx_last),
        .tx_valid     (ct_tx_valid),
        .tx_ready     (ct_tx_ready),
        .fifo_count   (ct_fifo_count),
        .pkt_count    (ct_pkt_count),
        .frame_err    (ct_frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words waiting to be offered, words the buffer should hold
    logic [34:0] gen_q[$];
    logic [32:0] exp_q[$];
    logic [34:0] cur = '0;
    logic        req_pending = 1'b0;
    logic [15:0] exp_pkts = '0;
    logic        exp_ferr = 1'b0;
    bit          allow_idle = 1'b0;
    bit          chk_en = 1'b0;
    int          ready_mode = 0;
    int          n_captured = 0;
    logic        prev_br = 1'b0;
    int          npk;
    logic        ev;

    logic [34:0] ct_gen_q[$];
    logic [32:0] ct_exp_q[$];
    logic [34:0] ct_cur = '0;
    logic        ct_pend = 1'b0;
    logic        ct_cap = 1'b0;
    int          ct_ncap = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_last(input logic [34:0] w);
        return w[34:32] != 3'b100;
    endfunction

    function automatic logic is_bad(input logic [34:0] w);
        return (w[34:32] != 3'b100) && (w[34:32] != 3'b000);
    endfunction

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((gen_q.size() != 0 || exp_q.size() != 0 || cur != '0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check(name, t < 5000, 1);
        @(negedge clk);
    endtask

    // Egress stage model for u_dut: answers each request pulse one cycle later
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                exp_q.delete();
                exp_pkts = '0;
                exp_ferr = 1'b0;
            end else if (cur != '0) begin
                exp_q.push_back({is_last(cur), cur[31:0]});
                if (is_bad(cur)) exp_ferr = 1'b1;
                n_captured++;
            end
            if (req_pending && !reset && gen_q.size() > 0 &&
                !(allow_idle && $urandom_range(0, 5) == 0)) begin
                cur = gen_q.pop_front();
            end else begin
                cur = '0;
            end
            data_in     = cur;
            req_pending = buffer_ready;
            case (ready_mode)
                1:       tx_ready = 1'b1;
                2:       tx_ready = 1'($urandom_range(0, 1));
                3:       begin tx_ready = 1'b1; ready_mode = 0; end
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor for u_dut
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                npk = 0;
                foreach (exp_q[i]) if (exp_q[i][32]) npk++;
                ev = (exp_q.size() > 0) && (npk > 0);
                check("tx_valid", tx_valid, ev);
                check("fifo_count", fifo_count, exp_q.size());
                check("pkt_count", pkt_count, exp_pkts);
                check("frame_err", frame_err, exp_ferr);
                if (buffer_ready) begin
                    check("req_gap", prev_br, 0);
                    check("req_space", fifo_count < DEPTH, 1);
                end
                if (tx_valid && exp_q.size() > 0) begin
                    check("tx_data", tx_data, exp_q[0][31:0]);
                    check("tx_last", tx_last, exp_q[0][32]);
                    if (tx_ready) begin
                        if (exp_q[0][32]) exp_pkts++;
                        void'(exp_q.pop_front());
                    end
                end else if (!tx_valid) begin
                    check("idle_data", {tx_last, tx_data}, 0);
                end
            end
            prev_br = buffer_ready;
        end
    end

    // Egress model and checker for the cut-through instance
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ct_cap = 1'b0;
            if (!reset && ct_cur != '0) begin
                ct_exp_q.push_back({is_last(ct_cur), ct_cur[31:0]});
                ct_cap = 1'b1;
            end
            if (ct_pend && !reset && ct_gen_q.size() > 0) ct_cur = ct_gen_q.pop_front();
            else ct_cur = '0;
            ct_data_in = ct_cur;
            ct_pend    = ct_buffer_ready;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ct_cap) begin
                    ct_ncap++;
                    if (ct_ncap == 1) check("ct_first_word_latency", {ct_tx_valid, ct_tx_data}, {1'b1, CtA});
                end
                if (ct_tx_valid) begin
                    if (ct_exp_q.size() == 0) begin
                        check("ct_unexpected_valid", ct_tx_valid, 0);
                    end else begin
                        check("ct_tx_data", ct_tx_data, ct_exp_q[0][31:0]);
                        check("ct_tx_last", ct_tx_last, ct_exp_q[0][32]);
                        void'(ct_exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int t;
        int pulses;

        repeat (3) @(negedge clk);
        check("rst_outputs", {buffer_ready, tx_valid, tx_last, tx_data, frame_err}, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_pkt_count", pkt_count, 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        ct_gen_q.push_back({3'b100, CtA});
        ct_gen_q.push_back({3'b100, 32'hC0DE_0002});
        ct_gen_q.push_back({3'b000, 32'hC0DE_0003});

        // Idle egress: request pulses alternate
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle_req%0d", i), buffer_ready, (i % 2) == 0);
        end

        // Three-word packet, store-and-forward
        ready_mode = 1;
        gen_q.push_back({3'b100, 32'hAAAA_0001});
        gen_q.push_back({3'b100, 32'hBBBB_0002});
        gen_q.push_back({3'b000, 32'hCCCC_0003});
        wait_drain("pkt3_drain");
        check("pkt3_count", pkt_count, 1);

        // Fill with transmitter stalled
        ready_mode = 0;
        for (int i = 0; i < 20; i++) begin
            w = 32'hF000_0000 + 32'(i + 1);
            gen_q.push_back({(i == 15) ? 3'b000 : 3'b100, w});
        end
        t = 0;
        while (fifo_count != DEPTH && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("fill_reached", fifo_count, DEPTH);
        repeat (6) begin
            @(negedge clk);
            check("full_no_req", buffer_ready, 0);
        end
        ready_mode = 3;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (buffer_ready) pulses++;
        end
        check("one_req_after_pop", pulses, 1);
        check("refilled", fifo_count, DEPTH);
        gen_q.push_back({3'b000, 32'hF000_00FF});
        ready_mode = 1;
        wait_drain("fill_drain");

        // Illegal flag
        gen_q.push_back({3'b010, 32'h5A5A_0001});
        wait_drain("ferr_drain");
        check("frame_err_set", frame_err, 1);
        gen_q.push_back({3'b100, 32'h1234_0001});
        gen_q.push_back({3'b000, 32'h1234_0002});
        wait_drain("ferr_sticky_drain");
        check("frame_err_sticky", frame_err, 1);

        // Randomized packets with random backpressure and egress gaps
        allow_idle = 1'b1;
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                logic [2:0] f;
                f = (k == len - 1) ? 3'b000 : 3'b100;
                if ($urandom_range(0, 19) == 0) begin
                    f = 3'($urandom_range(1, 7));
                    if (f == 3'b100) f = 3'b011;
                end
                w = $urandom;
                if (w == 32'd0) w = 32'd1;
                gen_q.push_back({f, w});
            end
        end
        wait_drain("random_drain");
        allow_idle = 1'b0;

        // Reset in the middle of an 8-word packet
        ready_mode = 1;
        t = n_captured;
        for (int i = 0; i < 8; i++) begin
            w = 32'hDEAD_0000 + 32'(i + 1);
            gen_q.push_back({(i == 7) ? 3'b000 : 3'b100, w});
        end
        pulses = 0;
        while (n_captured < t + 5 && pulses < 200) begin
            @(negedge clk);
            pulses++;
        end
        check("mid_pkt_5_captured", n_captured - t, 5);
        reset = 1'b1;
        gen_q.delete();
        @(negedge clk);
        check("mid_rst_outputs", {buffer_ready, tx_valid, tx_last, tx_data, frame_err}, 0);
        check("mid_rst_fifo_count", fifo_count, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        reset = 1'b0;
        gen_q.push_back({3'b100, 32'h7777_0001});
        gen_q.push_back({3'b000, 32'h7777_0002});
        wait_drain("post_reset_drain");
        check("post_reset_pkt_count", pkt_count, 1);

        check("ct_words_captured", ct_ncap, 3);
        check("ct_drained", ct_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
